card_dealer: RTL and testbench
==============================

# card_dealer

Responder side of the baccarat deal interface. It accepts the six one-hot load strobes issued by the game controller, draws a card from a free-running 1..13 shoe counter, and latches the card into the selected player or dealer slot. It also produces the running hand scores `pscore`/`dscore` and the raw `pcard3` value that the controller uses for its branching decisions. The block runs on the fast board clock and treats the controller's `slow_clock` as a sampled input.

## Interface
- `SYNC_STAGES`, default 2: synchroniser depth for `slow_clock` (minimum 2).
- `clk` input 1: fast clock (50 MHz); all state is updated on its rising edge.
- `resetb` input 1: reset, asynchronous, active-low.
- `slow_clock` input 1: controller clock, asynchronous to `clk`.
- `load_pcard1`, `load_pcard2`, `load_pcard3`, `load_dcard1`, `load_dcard2`, `load_dcard3` input 1 each: slot select; at most one high at a time.
- `pcard1`, `pcard2`, `pcard3` output 4: player card values; 0 = empty, 1..13 = A..K.
- `dcard1`, `dcard2`, `dcard3` output 4: dealer card values, same encoding.
- `pscore` output 4: player hand score, 0..9.
- `dscore` output 4: dealer hand score, 0..9.
- `cards_dealt` output 3: number of slots filled since reset, 0..6.
- `load_err` output 1: sticky flag; set when two or more load strobes were high at a commit point.

## Operation
- **Shoe counter** (4 bit):
  - Reset value 1.
  - Advances every `clk`: 1→2→…→13→1.
  - Values 0, 14 and 15 are never produced.
- **Edge detection**:
  - `slow_clock` passes through `SYNC_STAGES` flops, then one extra history flop.
  - A commit pulse `rise` is asserted for exactly one `clk` when the synchronised value is 1 and the history value is 0.
  - Commits happen on the synchronised rising edge because the controller changes its load vector on the falling edge. The vector is therefore stable for half a slow period around the rising edge.
- **Commit rules** (evaluated only in the cycle where `rise`=1):
  - Exactly one load bit high: the selected slot is written with the current shoe counter value, and `cards_dealt` increments, saturating at 6.
  - A slot is overwritten even if already non-zero. `cards_dealt` still increments (saturating) in that case.
  - No load bit high: no change.
  - Two or more load bits high: no slot is written, `cards_dealt` is unchanged, and `load_err` is set to 1. `load_err` stays at 1 until reset.
  - Load inputs are not synchronised. They are sampled only at `rise` and are required to be stable for at least `SYNC_STAGES+2` `clk` cycles around the `slow_clock` rising edge.
- **Scoring** (combinational from the registered slots):
  - Card value v maps to 0 if v = 0 or v ≥ 10, and to v otherwise.
  - `pscore` = (val(pcard1) + val(pcard2) + val(pcard3)) mod 10. The sum uses a 5-bit intermediate (maximum 27).
  - `dscore` uses the dealer slots in the same way.
- **Reset** (asynchronous assert, release synchronised to `clk` by the board):
  - All six slots = 0, `pscore` = `dscore` = 0, `cards_dealt` = 0, `load_err` = 0.
  - Shoe counter = 1 and the synchroniser/history flops = 0.
  - Reset mid-deal discards any pending edge; no commit occurs in the first cycle after release.

## Timing
- Commit latency: a slot updates on the `clk` edge that ends the `rise` cycle. This is `SYNC_STAGES`+1 to `SYNC_STAGES`+2 `clk` edges after the physical `slow_clock` rising edge.
- Score latency: `pscore`/`dscore` are valid in the same cycle the slot changes (zero-cycle combinational).
- Card value: the committed value is the shoe counter value present during the `rise` cycle, i.e. before that cycle's increment.
- Deterministic from reset: on the k-th `clk` edge after reset release, the counter equals (k mod 13)+1.
- Glitch rule: a `slow_clock` pulse shorter than one `clk` period may be missed; no double commit per rising edge is allowed.
- Scores are valid for the controller from its next falling edge onward, provided the slow half-period exceeds `SYNC_STAGES`+3 `clk` cycles.

## Test plan
- **Reset**: hold `resetb`=0 with random inputs toggling → all card outputs 0, `pscore`=`dscore`=0, `cards_dealt`=0, `load_err`=0. Counter reads 1 in the first cycle after release.
- **Player hand**: `load_pcard1` with a commit when the counter is 7, then `load_pcard2` with a commit when the counter is 5 → `pcard1`=7, `pcard2`=5, `pscore`=2, `cards_dealt`=2.
- **Face cards**: dealer slots committed with counter values 12, 10, 9 → `dcard1..3` = 12, 10, 9, `dscore`=9. Then overwrite `dcard3` with 13 → `dscore`=0, `cards_dealt`=4.
- **Multi-hot load**: load vector {`load_pcard1`, `load_pcard2`} both 1 at a rising edge → no slot changes, `load_err`=1, and it remains 1 after subsequent valid loads.
- **Wrap and saturation**: commit at counter 13, then 13 `clk` later at counter 13 again → both equal 13. After seven valid loads, `cards_dealt` stays at 6.
- **Reset mid-operation**: assert `resetb` one cycle after `slow_clock` rises with `load_dcard2` high → no commit, all outputs return to reset values. The first commit after release captures (k mod 13)+1.

Source files
------------

// File: rtl/card_dealer_if.sv
// Deal bus between the baccarat game controller and the card dealer.
// The controller owns slow_clock and the one-hot load strobes; the dealer
// returns the latched cards, running scores and bookkeeping flags.
interface card_dealer_if;
   logic       slow_clock;
   logic       load_pcard1, load_pcard2, load_pcard3;
   logic       load_dcard1, load_dcard2, load_dcard3;
   logic [3:0] pcard1, pcard2, pcard3;
   logic [3:0] dcard1, dcard2, dcard3;
   logic [3:0] pscore, dscore;
   logic [2:0] cards_dealt;
   logic       load_err;

   modport master (
      output slow_clock,
      output load_pcard1, load_pcard2, load_pcard3,
      output load_dcard1, load_dcard2, load_dcard3,
      input  pcard1, pcard2, pcard3, dcard1, dcard2, dcard3,
      input  pscore, dscore, cards_dealt, load_err
   );

   modport slave (
      input  slow_clock,
      input  load_pcard1, load_pcard2, load_pcard3,
      input  load_dcard1, load_dcard2, load_dcard3,
      output pcard1, pcard2, pcard3, dcard1, dcard2, dcard3,
      output pscore, dscore, cards_dealt, load_err
   );
endinterface

// File: rtl/card_dealer.sv
// Baccarat card dealer: free-running 1..13 shoe, slot latching on the
// synchronised rising edge of the controller's slow_clock, and hand scoring.
module card_dealer #(
   parameter int SYNC_STAGES = 2
) (
   input logic          clk,
   input logic          resetb,
   card_dealer_if.slave bus
);

   localparam int NUM_SLOTS = 6;  // bits 0..2 player 1..3, bits 3..5 dealer 1..3

   logic [3:0]                  shoe_q;
   logic [SYNC_STAGES-1:0]      sync_q;
   logic                        hist_q;
   logic                        synced;
   logic                        rise;
   logic [NUM_SLOTS-1:0]        load_vec;
   logic                        multi_hot;
   logic                        one_hot;
   logic [NUM_SLOTS-1:0][3:0]   slot_q;
   logic [2:0]                  dealt_q;
   logic                        err_q;
   logic [4:0]                  psum, dsum;

   // Card face to baccarat points: tens and faces (and empty) count zero.
   function automatic logic [3:0] card_val(input logic [3:0] v);
      return (v >= 4'd10) ? 4'd0 : v;
   endfunction

   assign load_vec  = {bus.load_dcard3, bus.load_dcard2, bus.load_dcard1,
                       bus.load_pcard3, bus.load_pcard2, bus.load_pcard1};
   // Clearing the lowest set bit leaves something only when two or more are set.
   assign multi_hot = (load_vec & (load_vec - 6'd1)) != '0;
   assign one_hot   = (load_vec != '0) && !multi_hot;

   assign synced    = sync_q[SYNC_STAGES-1];
   assign rise      = synced && !hist_q;

   // Shoe counter cycles 1..13 every fast clock, independent of the deal.
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb)               shoe_q <= 4'd1;
      else if (shoe_q == 4'd13)  shoe_q <= 4'd1;
      else                       shoe_q <= shoe_q + 4'd1;
   end

   // slow_clock synchroniser plus history flop for rising-edge detection.
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         sync_q <= '0;
         hist_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], bus.slow_clock};
         hist_q <= synced;
      end
   end

   // Commit: a single strobe latches the shoe into its slot; overwrites count too.
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         slot_q  <= '0;
         dealt_q <= '0;
      end else if (rise && one_hot) begin
         for (int i = 0; i < NUM_SLOTS; i++)
            if (load_vec[i]) slot_q[i] <= shoe_q;
         if (dealt_q != 3'd6) dealt_q <= dealt_q + 3'd1;
      end
   end

   // Sticky protocol-error flag for multi-hot strobes at a commit point.
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb)                err_q <= 1'b0;
      else if (rise && multi_hot) err_q <= 1'b1;
   end

   // Hand scores straight off the slots; max sum is 27, fits in 5 bits.
   always_comb begin
      psum = {1'b0, card_val(slot_q[0])} + {1'b0, card_val(slot_q[1])}
           + {1'b0, card_val(slot_q[2])};
      dsum = {1'b0, card_val(slot_q[3])} + {1'b0, card_val(slot_q[4])}
           + {1'b0, card_val(slot_q[5])};
   end

   assign bus.pscore      = 4'(psum % 5'd10);
   assign bus.dscore      = 4'(dsum % 5'd10);
   assign bus.pcard1      = slot_q[0];
   assign bus.pcard2      = slot_q[1];
   assign bus.pcard3      = slot_q[2];
   assign bus.dcard1      = slot_q[3];
   assign bus.dcard2      = slot_q[4];
   assign bus.dcard3      = slot_q[5];
   assign bus.cards_dealt = dealt_q;
   assign bus.load_err    = err_q;

endmodule

// File: tb/tb_card_dealer.sv
// Bench for card_dealer: directed table, hand-written corner sequences and
// randomized deals against a slot/score model driven by the clock count.
module tb_card_dealer;
   localparam int SS = 2;
   localparam logic [5:0] P1 = 6'b000001, P2 = 6'b000010, P3 = 6'b000100;
   localparam logic [5:0] D1 = 6'b001000, D2 = 6'b010000, D3 = 6'b100000;

   typedef struct {
      bit         rst;
      logic [5:0] ld;
      int         tgt;
      int         ps, ds, dealt, err;
   } vec_t;

   logic clk = 1'b0;
   logic resetb = 1'b0;
   int   edge_k;
   int   checks = 0, failures = 0;
   int   m_slot[6];
   int   m_dealt, m_err;
   int   last_ke;
   vec_t tbl[10];

   card_dealer_if bus();

   card_dealer #(.SYNC_STAGES(SS)) dut (
      .clk(clk), .resetb(resetb), .bus(bus)
   );

   always #10 clk = ~clk;

   // Clock edges since reset release: the shoe shows (edge_k mod 13)+1.
   always @(posedge clk or negedge resetb)
      if (!resetb) edge_k <= 0;
      else         edge_k <= edge_k + 1;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   function automatic int pts(input int v);
      return (v >= 10) ? 0 : v;
   endfunction

   function automatic int m_score(input int base);
      return (pts(m_slot[base]) + pts(m_slot[base+1]) + pts(m_slot[base+2])) % 10;
   endfunction

   function automatic int dut_slot(input int i);
      case (i)
         0: return int'(bus.pcard1);
         1: return int'(bus.pcard2);
         2: return int'(bus.pcard3);
         3: return int'(bus.dcard1);
         4: return int'(bus.dcard2);
         default: return int'(bus.dcard3);
      endcase
   endfunction

   task automatic set_loads(input logic [5:0] v);
      {bus.load_dcard3, bus.load_dcard2, bus.load_dcard1,
       bus.load_pcard3, bus.load_pcard2, bus.load_pcard1} = v;
   endtask

   task automatic check_model(input string tag);
      for (int i = 0; i < 6; i++)
         chk($sformatf("%s_slot%0d", tag, i), dut_slot(i), m_slot[i]);
      chk({tag, "_pscore"}, int'(bus.pscore), m_score(0));
      chk({tag, "_dscore"}, int'(bus.dscore), m_score(3));
      chk({tag, "_dealt"}, int'(bus.cards_dealt), m_dealt);
      chk({tag, "_err"}, int'(bus.load_err), m_err);
   endtask

   task automatic model_clear();
      for (int i = 0; i < 6; i++) m_slot[i] = 0;
      m_dealt = 0;
      m_err   = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      resetb = 1'b0;
      bus.slow_clock = 1'b0;
      set_loads('0);
      model_clear();
      repeat (3) @(negedge clk);
      resetb = 1'b1;
   endtask

   // One full slow_clock period. tgt=1..13 aligns the raise so the captured
   // shoe value is tgt; tgt=0 uses 'extra' idle cycles instead.
   task automatic do_commit(input logic [5:0] v, input int tgt, input int extra,
                            input string tag);
      int ke, card, ones, old_dealt;
      @(negedge clk);
      set_loads(v);
      repeat (SS + 2) @(negedge clk);
      if (tgt != 0) begin
         for (int n = 0; n < 13 && ((edge_k + SS) % 13) + 1 != tgt; n++)
            @(negedge clk);
      end else begin
         repeat (extra) @(negedge clk);
      end
      bus.slow_clock = 1'b1;
      ke   = edge_k + 1;
      card = ((ke + SS - 1) % 13) + 1;
      if (tgt != 0) chk({tag, "_align"}, card, tgt);
      last_ke   = ke;
      old_dealt = m_dealt;
      repeat (SS) @(posedge clk);
      @(negedge clk);
      chk({tag, "_early"}, int'(bus.cards_dealt), old_dealt);
      @(posedge clk);
      @(negedge clk);
      ones = $countones(v);
      if (ones == 1) begin
         for (int i = 0; i < 6; i++) if (v[i]) m_slot[i] = card;
         if (m_dealt < 6) m_dealt++;
      end else if (ones > 1) begin
         m_err = 1;
      end
      check_model(tag);
      bus.slow_clock = 1'b0;
      repeat (SS + 3) @(negedge clk);
      chk({tag, "_nodouble"}, int'(bus.cards_dealt), m_dealt);
      set_loads('0);
   endtask

   initial begin
      int e1, r;
      logic [5:0] v;
      bus.slow_clock = 1'b0;
      set_loads('0);
      model_clear();
      last_ke = 0;

      tbl[0] = '{1'b1, P1,      7,  7, 0, 1, 0};
      tbl[1] = '{1'b0, P2,      5,  2, 0, 2, 0};
      tbl[2] = '{1'b1, D1,      12, 0, 0, 1, 0};
      tbl[3] = '{1'b0, D2,      10, 0, 0, 2, 0};
      tbl[4] = '{1'b0, D3,      9,  0, 9, 3, 0};
      tbl[5] = '{1'b0, D3,      13, 0, 0, 4, 0};
      tbl[6] = '{1'b0, P1 | P2, 3,  0, 0, 4, 1};
      tbl[7] = '{1'b0, P1,      4,  4, 0, 5, 1};
      tbl[8] = '{1'b0, P3,      13, 4, 0, 6, 1};
      tbl[9] = '{1'b0, P2,      8,  2, 0, 6, 1};

      // Reset held with inputs thrashing: everything stays at its reset value.
      repeat (2) @(negedge clk);
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         bus.slow_clock = 1'($urandom_range(0, 1));
         set_loads(6'($urandom));
         check_model($sformatf("rst_hold%0d", c));
      end
      bus.slow_clock = 1'b0;
      set_loads('0);
      @(negedge clk);
      resetb = 1'b1;
      chk("rst_shoe_first", int'(dut.shoe_q), 1);

      // Directed table: player hand, face cards, multi-hot, saturation.
      for (int t = 0; t < 10; t++) begin
         if (tbl[t].rst) do_reset();
         do_commit(tbl[t].ld, tbl[t].tgt, 0, $sformatf("tbl%0d", t));
         chk($sformatf("tbl%0d_ps", t), int'(bus.pscore), tbl[t].ps);
         chk($sformatf("tbl%0d_ds", t), int'(bus.dscore), tbl[t].ds);
         chk($sformatf("tbl%0d_dealt", t), int'(bus.cards_dealt), tbl[t].dealt);
         chk($sformatf("tbl%0d_err", t), int'(bus.load_err), tbl[t].err);
      end
      chk("tbl_p1_kept", int'(bus.pcard1), 4);

      // Wrap: two captures at 13, a whole number of shoe periods apart.
      do_reset();
      do_commit(P1, 13, 0, "wrap_a");
      e1 = last_ke;
      do_commit(P2, 13, 0, "wrap_b");
      chk("wrap_gap_mod13", (last_ke - e1) % 13, 0);
      chk("wrap_p1", int'(bus.pcard1), 13);
      chk("wrap_p2", int'(bus.pcard2), 13);

      // Reset one cycle after slow_clock rises with load_dcard2: nothing lands.
      @(negedge clk);
      set_loads(D2);
      repeat (SS + 2) @(negedge clk);
      bus.slow_clock = 1'b1;
      @(posedge clk);
      @(negedge clk);
      resetb = 1'b0;
      bus.slow_clock = 1'b0;
      set_loads('0);
      model_clear();
      repeat (3) @(negedge clk);
      check_model("midrst_hold");
      resetb = 1'b1;
      chk("midrst_shoe_first", int'(dut.shoe_q), 1);
      repeat (6) @(negedge clk);
      check_model("midrst_idle");
      do_commit(P3, 0, int'($urandom_range(0, 12)), "midrst_first");
      chk("midrst_card", int'(bus.pcard3), ((last_ke + SS - 1) % 13) + 1);

      // Randomized deals against the model.
      do_reset();
      for (int n = 0; n < 40; n++) begin
         r = int'($urandom_range(0, 9));
         if (r == 0)      v = '0;
         else if (r == 1) v = (6'd1 << $urandom_range(0, 2)) | (6'd8 << $urandom_range(0, 2));
         else             v = 6'd1 << $urandom_range(0, 5);
         do_commit(v, 0, int'($urandom_range(0, 12)), $sformatf("rnd%0d", n));
         if (n == 20) begin
            do_reset();
            check_model("rnd_rst");
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
